// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_bus_arbiter_pkg;

    localparam int unsigned CntMax = 15;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic {
        StIdle,
        StRdWait
    } state_e;

    typedef enum logic {
        OwnCpu,
        OwnDma
    } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive arbitrations the DMA has lost.
module arb_starve_counter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int unsigned StarveMax = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [CntW-1:0] MaxVal = CntW'(StarveMax);

    logic [CntW-1:0] r_cnt;
    logic            w_at_max;

    assign w_at_max = (r_cnt >= MaxVal);
    assign o_at_max = w_at_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Arbitrates the data-memory port between the core MEM stage (priority) and a DMA,
// sequencing read latency and driving the core stall.
module dmem_bus_arbiter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iCpuRead,
    input  logic              iCpuWrite,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuWData,
    output logic [DATA_W-1:0] oCpuRData,
    output logic              oCpuStall,
    input  logic              iDmaRead,
    input  logic              iDmaWrite,
    input  logic [ADDR_W-1:0] iDmaAddr,
    input  logic [DATA_W-1:0] iDmaWData,
    output logic              oDmaGnt,
    output logic              oDmaDone,
    output logic [DATA_W-1:0] oDmaRData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemRead,
    output logic              oMemWrite,
    output logic [DATA_W-1:0] oMemWriteData,
    input  logic [DATA_W-1:0] iMemReadData,
    output logic              oBusy
);

    localparam logic [CntW-1:0] RdLatVal = CntW'(RD_LAT);

    state_e            r_state;
    owner_e            r_owner;
    logic [CntW-1:0]   r_lat;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    state_e            w_state_d;
    owner_e            w_issue_owner;
    logic [CntW-1:0]   w_lat_d;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_dma_gnt;
    logic              w_dma_done;
    logic              w_cpu_done;
    logic              w_rd_done;
    logic              w_issue_rd;
    logic              w_cpu_req;
    logic              w_dma_req;
    logic              w_cpu_sel;
    logic              w_starve_max;
    logic              w_inc;
    logic              w_clr;

    assign w_cpu_req = iCpuRead | iCpuWrite;
    assign w_dma_req = iDmaRead | iDmaWrite;
    // Core wins unless the DMA is both starved and actually asking.
    assign w_cpu_sel = w_cpu_req && (!w_starve_max || !w_dma_req);

    always_comb begin
        w_state_d     = r_state;
        w_lat_d       = r_lat;
        w_issue_owner = OwnCpu;
        w_mem_addr    = '0;
        w_mem_wdata   = '0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_dma_gnt     = 1'b0;
        w_dma_done    = 1'b0;
        w_cpu_done    = 1'b0;
        w_rd_done     = 1'b0;
        w_issue_rd    = 1'b0;
        w_inc         = 1'b0;
        w_clr         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_cpu_sel) begin
                    w_mem_addr = iCpuAddr;
                    w_inc      = w_dma_req;
                    if (iCpuWrite) begin
                        w_mem_write = 1'b1;
                        w_mem_wdata = iCpuWData;
                        w_cpu_done  = 1'b1;
                    end else begin
                        w_mem_read = 1'b1;
                        w_issue_rd = 1'b1;
                    end
                end else if (w_dma_req) begin
                    w_mem_addr    = iDmaAddr;
                    w_dma_gnt     = 1'b1;
                    w_clr         = 1'b1;
                    w_issue_owner = OwnDma;
                    if (iDmaWrite) begin
                        w_mem_write = 1'b1;
                        w_mem_wdata = iDmaWData;
                        w_dma_done  = 1'b1;
                    end else begin
                        w_mem_read = 1'b1;
                        w_issue_rd = 1'b1;
                    end
                end
                if (w_issue_rd) begin
                    w_state_d = StRdWait;
                    w_lat_d   = RdLatVal;
                end
            end
            StRdWait: begin
                w_mem_addr = r_addr;
                w_lat_d    = r_lat - 1'b1;
                if (r_lat == CntW'(1)) begin
                    w_rd_done = 1'b1;
                    w_state_d = StIdle;
                    if (r_owner == OwnCpu) w_cpu_done = 1'b1;
                    else                   w_dma_done = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_owner     <= OwnCpu;
            r_lat       <= '0;
            r_addr      <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            r_lat   <= w_lat_d;
            if (w_issue_rd) begin
                r_addr  <= w_mem_addr;
                r_owner <= w_issue_owner;
            end
            if (w_rd_done) begin
                if (r_owner == OwnCpu) r_cpu_rdata <= iMemReadData;
                else                   r_dma_rdata <= iMemReadData;
            end
        end
    end

    arb_starve_counter #(
        .StarveMax (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .i_inc    (w_inc),
        .i_clr    (w_clr),
        .o_at_max (w_starve_max)
    );

    // IDLE outputs are combinational from requests, so mask them while reset is held.
    assign oMemAddr      = reset ? w_mem_addr  : '0;
    assign oMemWriteData = reset ? w_mem_wdata : '0;
    assign oMemRead      = reset & w_mem_read;
    assign oMemWrite     = reset & w_mem_write;
    assign oDmaGnt       = reset & w_dma_gnt;
    assign oDmaDone      = reset & w_dma_done;
    assign oCpuStall     = reset & w_cpu_req & ~w_cpu_done;
    assign oBusy         = (r_state == StRdWait);

    assign oCpuRData = (w_rd_done && r_owner == OwnCpu) ? iMemReadData : r_cpu_rdata;
    assign oDmaRData = (w_rd_done && r_owner == OwnDma) ? iMemReadData : r_dma_rdata;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected memory accesses and read data, a
// negedge monitor pops and compares whenever the arbiter presents them.
module tb_dmem_bus_arbiter;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_tot = 0;
    int          n_bad = 0;

    mem_exp_t    exp_mem[$];
    logic [31:0] exp_cpu[$];
    logic [31:0] exp_dma[$];

    // Main DUT: RD_LAT=3, STARVE_MAX=4
    logic        cpu_rd, cpu_wr, dma_rd, dma_wr;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_stall, dma_gnt, dma_done, mem_rd, mem_wr, busy;

    // Second DUT: RD_LAT=1, core-only stimulus
    logic        d1_rd;
    logic [31:0] d1_addr, d1_mrdata;
    logic [31:0] d1_cpu_rdata, d1_dma_rdata, d1_mem_addr, d1_mem_wdata;
    logic        d1_stall, d1_gnt, d1_done, d1_mem_rd, d1_mem_wr, d1_busy;

    // Memory model for the main DUT: data = addr ^ C0DE_0000, valid 3 cycles after issue
    int          mdl_cnt;
    logic [31:0] mdl_data;

    always #5 clk = ~clk;

    dmem_bus_arbiter #(
        .RD_LAT     (3),
        .STARVE_MAX (4),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) u_dut (
        .clk           (clk),
        .reset         (rst_n),
        .iCpuRead      (cpu_rd),
        .iCpuWrite     (cpu_wr),
        .iCpuAddr      (cpu_addr),
        .iCpuWData     (cpu_wdata),
        .oCpuRData     (cpu_rdata),
        .oCpuStall     (cpu_stall),
        .iDmaRead      (dma_rd),
        .iDmaWrite     (dma_wr),
        .iDmaAddr      (dma_addr),
        .iDmaWData     (dma_wdata),
        .oDmaGnt       (dma_gnt),
        .oDmaDone      (dma_done),
        .oDmaRData     (dma_rdata),
        .oMemAddr      (mem_addr),
        .oMemRead      (mem_rd),
        .oMemWrite     (mem_wr),
        .oMemWriteData (mem_wdata),
        .iMemReadData  (mem_rdata),
        .oBusy         (busy)
    );

    dmem_bus_arbiter #(
        .RD_LAT     (1),
        .STARVE_MAX (4),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) u_dut1 (
        .clk           (clk),
        .reset         (rst_n),
        .iCpuRead      (d1_rd),
        .iCpuWrite     (1'b0),
        .iCpuAddr      (d1_addr),
        .iCpuWData     (32'h0),
        .oCpuRData     (d1_cpu_rdata),
        .oCpuStall     (d1_stall),
        .iDmaRead      (1'b0),
        .iDmaWrite     (1'b0),
        .iDmaAddr      (32'h0),
        .iDmaWData     (32'h0),
        .oDmaGnt       (d1_gnt),
        .oDmaDone      (d1_done),
        .oDmaRData     (d1_dma_rdata),
        .oMemAddr      (d1_mem_addr),
        .oMemRead      (d1_mem_rd),
        .oMemWrite     (d1_mem_wr),
        .oMemWriteData (d1_mem_wdata),
        .iMemReadData  (d1_mrdata),
        .oBusy         (d1_busy)
    );

    assign mem_rdata = (mdl_cnt == 1) ? mdl_data : 32'hFFFF_FFFF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt  <= 0;
            mdl_data <= 32'h0;
        end else if (mem_rd) begin
            mdl_cnt  <= 3;
            mdl_data <= mem_addr ^ 32'hC0DE_0000;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mem_exp_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                    input logic [31:0] d);
        mem_exp_t e;
        e.rd    = rd;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = d;
        return e;
    endfunction

    // Monitor: every strobe, core read completion and DMA done consumes one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd || mem_wr) begin
                if (exp_mem.size() == 0) begin
                    n_tot++;
                    n_bad++;
                    $display("FAIL mem_extra: got access at 0x%0h want none", mem_addr);
                end else begin
                    mem_exp_t e;
                    e = exp_mem.pop_front();
                    check("mem_rd", 64'(mem_rd), 64'(e.rd));
                    check("mem_wr", 64'(mem_wr), 64'(e.wr));
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.wr) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
            if (cpu_rd && !cpu_wr && !cpu_stall) begin
                if (exp_cpu.size() == 0) begin
                    n_tot++;
                    n_bad++;
                    $display("FAIL cpu_extra: got completion 0x%0h want none", cpu_rdata);
                end else begin
                    check("cpu_rdata", 64'(cpu_rdata), 64'(exp_cpu.pop_front()));
                end
            end
            if (dma_done) begin
                if (exp_dma.size() == 0) begin
                    n_tot++;
                    n_bad++;
                    $display("FAIL dma_extra: got done 0x%0h want none", dma_rdata);
                end else begin
                    check("dma_rdata", 64'(dma_rdata), 64'(exp_dma.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_rd = 1'b0; dma_wr = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        d1_rd  = 1'b0; d1_addr = 32'h0; d1_mrdata = 32'h0;

        // Request held during reset must not leak to outputs
        @(negedge clk);
        check("rst_quiet", {mem_wr, mem_rd, cpu_stall, dma_gnt, busy}, 0);
        cpu_wr = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_flags", {mem_rd, mem_wr, cpu_stall, busy, dma_gnt, dma_done}, 0);
        check("idle_addr", mem_addr, 0);
        check("idle_rdata", {cpu_rdata, dma_rdata}, 0);

        // RD_LAT=1 core read
        tick();
        d1_rd = 1'b1; d1_addr = 32'h10; d1_mrdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("d1_issue", {d1_mem_rd, d1_stall, d1_busy}, 3'b110);
        check("d1_addr", d1_mem_addr, 32'h10);
        tick();
        @(negedge clk);
        check("d1_done", {d1_mem_rd, d1_stall, d1_busy}, 3'b001);
        check("d1_rdata", d1_cpu_rdata, 32'hDEAD_BEEF);
        tick();
        d1_rd = 1'b0; d1_mrdata = 32'h0;
        @(negedge clk);
        check("d1_hold", d1_cpu_rdata, 32'hDEAD_BEEF);
        check("d1_quiet1", {d1_busy, d1_gnt, d1_done, d1_mem_wr}, 0);
        check("d1_quiet2", {d1_dma_rdata, d1_mem_wdata}, 0);

        // Starvation: C C C C D, counter cleared, C C C C D again
        tick();
        cpu_wr = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234;
        dma_wr = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h5555;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                exp_mem.push_back(mk(1'b0, 1'b1, 32'h40, 32'h5555));
                exp_dma.push_back(32'h0);
            end else begin
                exp_mem.push_back(mk(1'b0, 1'b1, 32'h20, 32'h1234));
            end
        end
        for (int i = 0; i < 10; i++) begin
            logic dcyc;
            dcyc = (i == 4 || i == 9);
            @(negedge clk);
            check($sformatf("starve_gnt%0d", i), {dma_gnt, dma_done, cpu_stall}, {3{dcyc}});
            tick();
        end
        cpu_wr = 1'b0; dma_wr = 1'b0;

        // Simultaneous reads, RD_LAT=3: core first, DMA at next idle cycle
        cpu_rd = 1'b1; cpu_addr = 32'h100;
        dma_rd = 1'b1; dma_addr = 32'h200;
        exp_mem.push_back(mk(1'b1, 1'b0, 32'h100, 32'h0));
        exp_mem.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0));
        exp_cpu.push_back(32'hC0DE_0100);
        exp_dma.push_back(32'hC0DE_0200);
        for (int c = 0; c < 8; c++) begin
            logic eb;
            eb = (c >= 1 && c <= 3) || (c >= 5);
            @(negedge clk);
            check($sformatf("rd_busy%0d", c), {busy, dma_gnt, dma_done},
                  {eb, c == 4, c == 7});
            if (c <= 3) check($sformatf("rd_stall%0d", c), cpu_stall, c != 3);
            tick();
            if (c == 3) cpu_rd = 1'b0;
            if (c == 7) dma_rd = 1'b0;
        end
        @(negedge clk);
        check("rd_hold", {cpu_rdata, dma_rdata}, {32'hC0DE_0100, 32'hC0DE_0200});
        check("rd_idle", busy, 0);

        // Read+write together: write wins, no RDWAIT
        tick();
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'h77;
        exp_mem.push_back(mk(1'b0, 1'b1, 32'h8, 32'h77));
        @(negedge clk);
        check("rw_strobes", {mem_rd, mem_wr, cpu_stall}, 3'b010);
        tick();
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
        check("rw_nobusy", {busy, mem_rd, mem_wr}, 0);

        // Reset in the 2nd RDWAIT cycle abandons the DMA read
        tick();
        dma_rd = 1'b1; dma_addr = 32'h300;
        exp_mem.push_back(mk(1'b1, 1'b0, 32'h300, 32'h0));
        @(negedge clk);
        check("ab_gnt", dma_gnt, 1);
        tick();
        @(negedge clk);
        check("ab_busy1", busy, 1);
        tick();
        @(negedge clk);
        check("ab_busy2", busy, 1);
        rst_n = 1'b0; dma_rd = 1'b0;
        #1;
        check("ab_rst", {busy, dma_done}, 0);
        @(negedge clk);
        check("ab_rst_rdata", {dma_done, dma_rdata}, 0);
        tick();
        rst_n = 1'b1;
        cpu_wr = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'hABCD;
        exp_mem.push_back(mk(1'b0, 1'b1, 32'h50, 32'hABCD));
        @(negedge clk);
        check("post_rst_wr", {mem_wr, cpu_stall, busy}, 3'b100);
        check("post_rst_addr", mem_addr, 32'h50);
        tick();
        cpu_wr = 1'b0;
        repeat (5) @(negedge clk);

        check("left_mem", exp_mem.size(), 0);
        check("left_cpu", exp_cpu.size(), 0);
        check("left_dma", exp_dma.size(), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
Shares the single data-memory port between the pipeline core's MEM stage and a DMA requester. The core has priority, and a starvation counter guarantees the DMA a slot. The block sequences memory read latency and drives the core's stall so MEM/WB captures read data only on the valid cycle. It sits between the core's memory-side outputs and the data RAM/peripheral bus.

Parameters:
RD_LAT, 1, memory read latency in cycles from issue to data valid; legal range 1..7
STARVE_MAX, 4, consecutive lost arbitrations after which the DMA is forced to win; legal range 1..15
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
iCpuRead  in  1  core read request (level)
iCpuWrite  in  1  core write request (level); overrides iCpuRead if both set
iCpuAddr  in  ADDR_W  core address
iCpuWData  in  DATA_W  core write data
oCpuRData  out  DATA_W  read data, valid when core read completes
oCpuStall  out  1  freeze IF..MEM stages
iDmaRead  in  1  DMA read request
iDmaWrite  in  1  DMA write request; overrides iDmaRead
iDmaAddr  in  ADDR_W  DMA address
iDmaWData  in  DATA_W  DMA write data
oDmaGnt  out  1  pulse: DMA command issued this cycle
oDmaDone  out  1  pulse: DMA transfer complete (oDmaRData valid for reads)
oDmaRData  out  DATA_W  DMA read data
oMemAddr  out  ADDR_W  memory address
oMemRead  out  1  memory read strobe (one cycle per access)
oMemWrite  out  1  memory write strobe (one cycle per access)
oMemWriteData  out  DATA_W  memory write data
iMemReadData  in  DATA_W  memory read data, valid RD_LAT cycles after oMemRead
oBusy  out  1  read in flight (state RDWAIT)

Behaviour:
- Reset (reset=0, async): state IDLE, owner CPU, latency and starvation counters 0, latched address/data 0. All outputs 0, including oCpuStall, while reset is low.
- States: IDLE, RDWAIT.
- IDLE arbitration is combinational from the requests. The command is driven in the same cycle.
  - Core wins if it is requesting and starve_cnt < STARVE_MAX.
  - Otherwise the DMA wins if it is requesting.
  - Otherwise the core wins if it is requesting.
- Write win: oMemWrite=1 with the winner's addr/data for one cycle. The access completes that cycle and the state stays IDLE, so back-to-back writes take one cycle each.
- Read win: oMemRead=1 for one cycle. Address is latched, owner is recorded, lat_cnt loads RD_LAT, state goes to RDWAIT.
- RDWAIT:
  - oMemRead=oMemWrite=0; oMemAddr holds the latched address.
  - lat_cnt decrements each cycle. The completion cycle is the one where lat_cnt==1.
  - On completion, iMemReadData is forwarded combinationally to the owner's rdata port and the state returns to IDLE.
  - No arbitration takes place in RDWAIT.
- Read throughput is one read per RD_LAT+1 cycles.
- oCpuStall = core requesting AND not core-complete this cycle. A granted core write therefore has zero stall. A core read stalls RD_LAT cycles.
- oCpuRData and oDmaRData hold their last completed value between completions.
- oDmaGnt pulses in the DMA issue cycle. oDmaDone pulses at DMA completion, in the same cycle as oDmaGnt for writes.
- starve_cnt is updated only in IDLE cycles:
  - +1 (saturating at STARVE_MAX) when the DMA requests and the core wins.
  - Cleared when the DMA is granted.
  - Otherwise held.
- Requesters must hold request/addr/data stable until complete. If a request drops during RDWAIT, the access still completes and the done/data cycle still occurs.
- If reset asserts during RDWAIT, the in-flight read is abandoned and no done pulse occurs.

Decomposition:
- Shared package: state encoding (IDLE, RDWAIT), owner encoding (OWN_CPU, OWN_DMA), and a clog2-based width constant for the counters.
- One sub-module, arb_starve_counter: saturating counter with inc/clr inputs and an at-max output.

Test Plan:
- Reset release, no requests -> all outputs 0, state IDLE, oCpuStall=0.
- Core read 0x0000_0010 with RD_LAT=1, memory returns 0xDEADBEEF -> oMemRead pulses at cycle 0 and oCpuStall=1 at cycle 0; at cycle 1 oCpuRData=0xDEADBEEF and oCpuStall=0.
- Core write 0x20←0x1234 and DMA write 0x40 pending, STARVE_MAX=4, core writing continuously -> core writes for 4 cycles. In the 5th cycle oDmaGnt=oDmaDone=1, oMemAddr=0x40, oCpuStall=1 that cycle, and starve_cnt returns to 0.
- Core and DMA both assert read in the same cycle with starve_cnt=0, RD_LAT=3 -> core issues first and oBusy is high for 3 cycles. The DMA read issues at the following IDLE cycle and oDmaDone follows 3 cycles later with the correct data.
- Core asserts iCpuRead and iCpuWrite together, address 0x8 -> only oMemWrite pulses and no RDWAIT is entered.
- reset driven low in the 2nd RDWAIT cycle (RD_LAT=3), then released -> immediate IDLE, no oDmaDone/completion pulse, and a new request is accepted on the first cycle after release.
